// File: rtl/onchip_ram_dp.sv
// onchip_ram_dp: true-dual-port Avalon-MM RAM with byte enables, 1/2-cycle read latency,
// s1-priority write collisions, old-data mixed-port reads and zero-returning out-of-range reads
module onchip_ram_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int DEPTH        = 5120,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid
);
    localparam int NB = DATA_WIDTH / 8;
    localparam bit L2 = (READ_LATENCY == 2);
    localparam logic [ADDR_WIDTH:0] LIM = DEPTH[ADDR_WIDTH:0];
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [NB-1:0]         be [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [1:0]            cs, rq, wq, wr, rd, hit, v1, v2, vo;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] d1 [2];
    logic [DATA_WIDTH-1:0] d2 [2];
    assign en    = clken & ~reset_req & ~reset;
    assign addr  = '{s1_address, s2_address};
    assign be    = '{s1_byteenable, s2_byteenable};
    assign wdata = '{s1_writedata, s2_writedata};
    assign cs    = {s2_chipselect, s1_chipselect};
    assign rq    = {s2_read, s1_read};
    assign wq    = {s2_write, s1_write};
    assign wr    = cs & wq & {2{en}};
    assign rd    = cs & rq & ~wq & {2{en}};
    for (genvar g = 0; g < 2; g++) begin : g_hit
        assign hit[g] = {1'b0, addr[g]} < LIM;
    end
    // s2 lanes are scheduled first so s1 overrides any lane both ports enable
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--)
            for (int i = 0; i < NB; i++)
                if (wr[p] && hit[p] && be[p][i])
                    mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
    end
    // final stage valid is a one-cycle pulse; inner stage holds across stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= '0;
            v2 <= '0;
            d1 <= '{default: '0};
            d2 <= '{default: '0};
        end else begin
            for (int p = 0; p < 2; p++) begin
                v1[p] <= rd[p] | (L2 & ~en & v1[p]);
                v2[p] <= en & v1[p];
                if (rd[p])
                    d1[p] <= hit[p] ? mem[addr[p]] : '0;
                if (en && v1[p])
                    d2[p] <= d1[p];
            end
        end
    end
    assign vo               = L2 ? v2 : v1;
    assign s1_readdata      = L2 ? d2[0] : d1[0];
    assign s2_readdata      = L2 ? d2[1] : d1[1];
    // a read whose result is due while reset is high is discarded immediately
    assign s1_readdatavalid = vo[0] & ~reset;
    assign s2_readdatavalid = vo[1] & ~reset;
endmodule

// File: tb/tb_onchip_ram_dp.sv
// tb_onchip_ram_dp: directed vector table on a latency-1 instance plus hand sequences for
// stalls (latency-2 instance), reset_req blocking and reset mid-read
module tb_onchip_ram_dp;
    logic        clk = 1'b0;
    logic        reset, reset_req, clken;
    logic [12:0] s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;
    logic [31:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
    logic        a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid;

    always #5 clk = ~clk;

    onchip_ram_dp #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_readdatavalid),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_readdatavalid)
    );

    onchip_ram_dp #(.READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  be;
        logic [12:0] a;
        logic [31:0] d;
    } req_t;

    typedef struct packed {
        req_t        r1;
        req_t        r2;
        logic        v1;
        logic [31:0] q1;
        logic        v2;
        logic [31:0] q2;
    } vec_t;

    localparam req_t NOP = '0;
    int passed = 0;
    int total  = 0;
    vec_t vt [17];

    function automatic req_t rdq(logic [12:0] a);
        return '{2'b01, 4'h0, a, 32'h0};
    endfunction

    function automatic req_t wrq(logic [12:0] a, logic [31:0] d, logic [3:0] be);
        return '{2'b10, be, a, d};
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic drive(req_t r1, req_t r2);
        s1_chipselect = |r1.op; s1_read = r1.op[0]; s1_write = r1.op[1];
        s1_byteenable = r1.be;  s1_address = r1.a;  s1_writedata = r1.d;
        s2_chipselect = |r2.op; s2_read = r2.op[0]; s2_write = r2.op[1];
        s2_byteenable = r2.be;  s2_address = r2.a;  s2_writedata = r2.d;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  expv_b, expv_a;
        logic [31:0] expd_b [8];
        logic [31:0] expd_a [8];
        // each row: requests presented at an edge, outputs of the latency-1 instance just after it
        vt[0]  = '{wrq(13'd5, 32'hDEADBEEF, 4'hF), NOP, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[1]  = '{rdq(13'd5), NOP, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[2]  = '{NOP, NOP, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[3]  = '{wrq(13'd7, 32'h11223344, 4'hF), NOP, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[4]  = '{NOP, wrq(13'd7, 32'hAABBCCDD, 4'h5), 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[5]  = '{rdq(13'd7), NOP, 1'b1, 32'h11BB33DD, 1'b0, 32'h0};
        vt[6]  = '{wrq(13'd9, 32'h000000FF, 4'h1), wrq(13'd9, 32'hABCDEF01, 4'hF), 1'b0, 32'h11BB33DD, 1'b0, 32'h0};
        vt[7]  = '{rdq(13'd9), NOP, 1'b1, 32'hABCDEFFF, 1'b0, 32'h0};
        vt[8]  = '{wrq(13'd9, 32'h00000001, 4'hF), rdq(13'd9), 1'b0, 32'hABCDEFFF, 1'b1, 32'hABCDEFFF};
        vt[9]  = '{NOP, rdq(13'd9), 1'b0, 32'hABCDEFFF, 1'b1, 32'h00000001};
        vt[10] = '{wrq(13'd5200, 32'h12345678, 4'hF), NOP, 1'b0, 32'hABCDEFFF, 1'b0, 32'h00000001};
        vt[11] = '{rdq(13'd5200), NOP, 1'b1, 32'h0, 1'b0, 32'h00000001};
        vt[12] = '{wrq(13'd5119, 32'hCAFEF00D, 4'hF), NOP, 1'b0, 32'h0, 1'b0, 32'h00000001};
        vt[13] = '{NOP, rdq(13'd5119), 1'b0, 32'h0, 1'b1, 32'hCAFEF00D};
        vt[14] = '{'{2'b11, 4'hF, 13'd5, 32'h55555555}, NOP, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D};
        vt[15] = '{rdq(13'd5), wrq(13'd8191, 32'h77777777, 4'hF), 1'b1, 32'h55555555, 1'b0, 32'hCAFEF00D};
        vt[16] = '{rdq(13'd8191), rdq(13'd5), 1'b1, 32'h0, 1'b1, 32'h55555555};

        reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
        drive(NOP, NOP);
        repeat (2) cyc();
        chk("reset a s1 valid", {31'b0, a_s1_readdatavalid}, 32'h0);
        chk("reset a s1 data", a_s1_readdata, 32'h0);
        chk("reset a s2 valid", {31'b0, a_s2_readdatavalid}, 32'h0);
        chk("reset b s1 valid", {31'b0, b_s1_readdatavalid}, 32'h0);
        chk("reset b s2 data", b_s2_readdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].r1, vt[i].r2);
            cyc();
            chk($sformatf("vec%0d s1 valid", i), {31'b0, a_s1_readdatavalid}, {31'b0, vt[i].v1});
            chk($sformatf("vec%0d s1 data", i), a_s1_readdata, vt[i].q1);
            chk($sformatf("vec%0d s2 valid", i), {31'b0, a_s2_readdatavalid}, {31'b0, vt[i].v2});
            chk($sformatf("vec%0d s2 data", i), a_s2_readdata, vt[i].q2);
        end

        // stall: reads of 0,1,2 with clken low for the two edges after the second accept
        drive(wrq(13'd0, 32'hA0, 4'hF), wrq(13'd1, 32'hA1, 4'hF)); cyc();
        drive(wrq(13'd2, 32'hA2, 4'hF), NOP); cyc();
        expv_b = 8'b0011_0010;
        expd_b = '{32'h0, 32'hA0, 32'h0, 32'h0, 32'hA1, 32'hA2, 32'h0, 32'h0};
        expv_a = 8'b0001_0011;
        expd_a = '{32'hA0, 32'hA1, 32'h0, 32'h0, 32'hA2, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < 8; k++) begin
            clken = !(k == 2 || k == 3);
            drive(k < 5 ? rdq(k < 2 ? k[12:0] : 13'd2) : NOP, NOP);
            cyc();
            chk($sformatf("stall b t%0d valid", k), {31'b0, b_s1_readdatavalid}, {31'b0, expv_b[k]});
            if (expv_b[k]) chk($sformatf("stall b t%0d data", k), b_s1_readdata, expd_b[k]);
            chk($sformatf("stall a t%0d valid", k), {31'b0, a_s1_readdatavalid}, {31'b0, expv_a[k]});
            if (expv_a[k]) chk($sformatf("stall a t%0d data", k), a_s1_readdata, expd_a[k]);
        end
        clken = 1'b1;

        // reset_req blocks both ports
        drive(wrq(13'd20, 32'h0BADF00D, 4'hF), wrq(13'd21, 32'h21212121, 4'hF)); cyc();
        reset_req = 1'b1;
        drive(wrq(13'd21, 32'hFFFFFFFF, 4'hF), rdq(13'd20)); cyc();
        chk("reset_req s2 no valid", {31'b0, a_s2_readdatavalid}, 32'h0);
        reset_req = 1'b0;
        drive(rdq(13'd21), NOP); cyc();
        chk("reset_req kept word valid", {31'b0, a_s1_readdatavalid}, 32'h1);
        chk("reset_req kept word data", a_s1_readdata, 32'h21212121);

        // reset arrives on the edge after a read accept
        drive(rdq(13'd20), NOP);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(wrq(13'd20, 32'hFFFFFFFF, 4'hF), rdq(13'd20));
        @(negedge clk);
        chk("midrst a valid pre", {31'b0, a_s1_readdatavalid}, 32'h0);
        cyc();
        chk("midrst a valid", {31'b0, a_s1_readdatavalid}, 32'h0);
        chk("midrst a data", a_s1_readdata, 32'h0);
        chk("midrst b valid", {31'b0, b_s1_readdatavalid}, 32'h0);
        chk("midrst b data", b_s1_readdata, 32'h0);
        reset = 1'b0;
        drive(NOP, NOP);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("postrst t%0d a valid", k), {31'b0, a_s1_readdatavalid | a_s2_readdatavalid}, 32'h0);
            chk($sformatf("postrst t%0d b valid", k), {31'b0, b_s1_readdatavalid | b_s2_readdatavalid}, 32'h0);
        end
        drive(rdq(13'd20), NOP); cyc();
        chk("preserved valid", {31'b0, a_s1_readdatavalid}, 32'h1);
        chk("preserved data", a_s1_readdata, 32'h0BADF00D);
        drive(NOP, NOP); cyc();
        chk("preserved b valid", {31'b0, b_s1_readdatavalid}, 32'h1);
        chk("preserved b data", b_s1_readdata, 32'h0BADF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/onchip_ram_dp.md
Name: onchip_ram_dp

Overview:
- Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports, s1 and s2, on one clock.
- Adds configurable width and depth, 1- or 2-cycle read latency, readdatavalid per port, defined collision rules and out-of-range handling.
- Sits in the Qsys system as a shared program/data memory: CPU on s1, DMA or second master on s2.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 13, word address width.
- DEPTH, 5120, number of words; must be at most 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; 1 or 2 (2 adds an output register).
- INIT_FILE, "onchip_ram.hex", memory initialisation file; contents are loaded at configuration, not at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- reset_req  in  1  high = stall both ports; no accept, no pipeline advance.
- clken  in  1  global clock enable; low = stall as reset_req.
- s1_address  in  ADDR_WIDTH  word address.
- s1_chipselect  in  1  port select.
- s1_read  in  1  read strobe.
- s1_write  in  1  write strobe.
- s1_byteenable  in  DATA_WIDTH/8  byte lanes for writes.
- s1_writedata  in  DATA_WIDTH  write data.
- s1_readdata  out  DATA_WIDTH  read data.
- s1_readdatavalid  out  1  s1_readdata valid this cycle.
- s2_* : identical set to s1_*.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Enable: en = clken & ~reset_req. When en=0, nothing is accepted, RAM is not written, pipeline registers and outputs hold.
- Accept: a port accepts a read when chipselect & read & en, and a write when chipselect & write & en. read and write together on one port is illegal. If it occurs, the write is performed and the read is ignored (no readdatavalid). There is no waitrequest; every request is accepted in the cycle it is presented while en=1.
- Write: on the accepting clk edge, byte lane i of the word at address is updated from writedata[8i+7:8i] iff byteenable[i]=1.
- Read pipeline, READ_LATENCY=1: array read registered on the accepting edge. readdata and readdatavalid=1 appear in the next cycle and last exactly one cycle.
- Read pipeline, READ_LATENCY=2: one additional register stage; data and valid appear 2 cycles after accept. Back-to-back reads on every cycle give one result per cycle, in order.
- Valid pulse: readdatavalid drops to 0 the cycle after it was presented unless a new result arrives. readdata holds its last value when valid=0.
- Stalls: an en=0 cycle freezes pipeline stages. Results are delayed by the number of stall cycles, never dropped or duplicated.
- Out of range: address >= DEPTH. Writes are ignored. Reads complete with normal latency and return all zeros.
- Read-during-write, same port: not possible (see illegal case above).
- Read-during-write, mixed ports, same address, same cycle: the reading port returns OLD data.
- Write collision, same address, same cycle: s1 wins on every byte lane it enables. s2 writes only the lanes that s1 does not enable.
- Reset:
  - s1/s2_readdatavalid = 0 and s1/s2_readdata = 0 in the cycle after reset is sampled high.
  - In-flight reads are discarded.
  - RAM contents are preserved.
  - Requests presented while reset=1 are not accepted.
  - reset takes priority over en.

Test Plan:
- READ_LATENCY=1: s1 write 0xDEADBEEF to addr 5 (be=0xF), then s1 read addr 5 -> one cycle later s1_readdata=0xDEADBEEF, s1_readdatavalid=1 for exactly 1 cycle.
- Byte enables: word 7 = 0x11223344, s2 write 0xAABBCCDD be=0b0101 -> s1 read addr 7 returns 0x11BB33DD.
- Collision: same cycle, s1 writes 0x000000FF (be=0x1) and s2 writes 0xABCDEF01 (be=0xF) to addr 9 -> read gives 0xABCDEFFF. Mixed read: s2 reads addr 9 while s1 writes 0x1 there -> s2 gets the old value.
- READ_LATENCY=2, stalls: s1 reads addrs 0,1,2 on consecutive cycles, with clken=0 for 2 cycles after the second accept -> three valid results in order, the last two delayed by 2 cycles, none duplicated.
- Out of range (DEPTH=5120): write 0x12345678 to addr 5200, then read it -> returns 0x00000000 with normal latency. Address 5119 still reads/writes normally.
- Reset mid-read: s1 read accepted with reset=1 on the next edge -> no readdatavalid ever appears for it, readdata=0. A later read of a pre-reset written word returns its value (contents preserved).
